// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller:
// FSM states, datapath mux/ALU encodings, condition and command codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  // ALU operation select
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;

  // Immediate extension select
  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  // Result mux select
  localparam logic [1:0] RES_ALUREG = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALUOUT = 2'b10;

  // ALU operand selects
  localparam logic [1:0] SRCA_RN  = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;
  localparam logic [1:0] SRCB_RM  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  // Instruction class (op field)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Data-processing commands (funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] REG_PC = 4'd15;

  // True for the data-processing commands this controller implements
  function automatic logic cmd_valid(input logic [3:0] cmd);
    logic ok;
    case (cmd)
      CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV: ok = 1'b1;
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ALU operation driven for a data-processing command
  function automatic logic [2:0] cmd_alu(input logic [3:0] cmd);
    logic [2:0] alu;
    case (cmd)
      CMD_ADD: alu = ALU_ADD;
      CMD_SUB: alu = ALU_SUB;
      CMD_CMP: alu = ALU_SUB;
      CMD_AND: alu = ALU_AND;
      CMD_ORR: alu = ALU_ORR;
      CMD_MOV: alu = ALU_PASSB;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory handshake between the controller and the shared-memory datapath.
interface multicycle_control_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluation against the NZCV register.
// With COND_FULL=0 only EQ, NE and AL can pass.
module cond_check
  import mc_pkg::*;
#(
  parameter bit COND_FULL = 1'b1
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags_q,
  output logic       cond_ok
);

  logic n_s, z_s, c_s, v_s;
  logic full_ok_s;
  logic lite_ok_s;

  assign {n_s, z_s, c_s, v_s} = flags_q;

  // Full table of the fifteen architectural condition codes
  always_comb begin
    full_ok_s = 1'b0;
    case (cond)
      COND_EQ: full_ok_s = z_s;
      COND_NE: full_ok_s = ~z_s;
      COND_CS: full_ok_s = c_s;
      COND_CC: full_ok_s = ~c_s;
      COND_MI: full_ok_s = n_s;
      COND_PL: full_ok_s = ~n_s;
      COND_VS: full_ok_s = v_s;
      COND_VC: full_ok_s = ~v_s;
      COND_HI: full_ok_s = c_s & ~z_s;
      COND_LS: full_ok_s = ~c_s | z_s;
      COND_GE: full_ok_s = (n_s == v_s);
      COND_LT: full_ok_s = (n_s != v_s);
      COND_GT: full_ok_s = ~z_s & (n_s == v_s);
      COND_LE: full_ok_s = z_s | (n_s != v_s);
      COND_AL: full_ok_s = 1'b1;
      default: full_ok_s = 1'b0;
    endcase
  end

  // Reduced table: equality tests and always, everything else fails
  always_comb begin
    lite_ok_s = 1'b0;
    case (cond)
      COND_EQ: lite_ok_s = z_s;
      COND_NE: lite_ok_s = ~z_s;
      COND_AL: lite_ok_s = 1'b1;
      default: lite_ok_s = 1'b0;
    endcase
  end

  assign cond_ok = COND_FULL ? full_ok_s : lite_ok_s;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset controller: sequences fetch, decode, execute,
// memory and writeback, stalls on the memory ready handshake, and owns
// the architectural NZCV flag register.
module multicycle_control
  import mc_pkg::*;
#(
  parameter bit COND_FULL = 1'b1,
  parameter bit MEM_HS    = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3:0]                  cond,
  input  logic [1:0]                  op,
  input  logic [5:0]                  funct,
  input  logic [3:0]                  rd,
  input  logic [3:0]                  alu_flags,
  multicycle_control_if.master        mem,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        reg_write,
  output logic                        link,
  output logic [1:0]                  alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [2:0]                  alu_control,
  output logic [1:0]                  imm_src,
  output logic [1:0]                  result_src,
  output logic [3:0]                  flags_q,
  output logic                        undef
);

  state_e     state_q, state_d;
  logic [3:0] flags_d;
  logic       ready_s;
  logic       cond_ok_s;
  logic [3:0] cmd_s;
  logic       cmd_ok_s;
  logic       is_cmp_s;
  logic       rd_pc_s;

  logic       mem_req_s, mem_write_s, adr_src_s;
  logic       ir_write_s, pc_write_s, reg_write_s, link_s, undef_s;
  logic [1:0] alu_src_a_s, alu_src_b_s, imm_src_s, result_src_s;
  logic [2:0] alu_control_s;

  // Without a handshake every memory access completes in its first cycle
  assign ready_s  = MEM_HS ? mem.mem_ready : 1'b1;
  assign cmd_s    = funct[4:1];
  assign cmd_ok_s = cmd_valid(cmd_s);
  assign is_cmp_s = (cmd_s == CMD_CMP);
  assign rd_pc_s  = (rd == REG_PC);

  cond_check #(
    .COND_FULL (COND_FULL)
  ) u_cond_check (
    .cond    (cond),
    .flags_q (flags_q),
    .cond_ok (cond_ok_s)
  );

  // State and flag registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Next-state and control decode; flags only change when leaving EXEC
  always_comb begin
    state_d       = state_q;
    flags_d       = flags_q;
    mem_req_s     = 1'b0;
    mem_write_s   = 1'b0;
    adr_src_s     = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    link_s        = 1'b0;
    undef_s       = 1'b0;
    alu_src_a_s   = SRCA_RN;
    alu_src_b_s   = SRCB_RM;
    alu_control_s = ALU_ADD;
    imm_src_s     = IMM_8;
    result_src_s  = RES_ALUREG;

    case (state_q)
      S_FETCH: begin
        mem_req_s     = 1'b1;
        alu_src_a_s   = SRCA_PC;
        alu_src_b_s   = SRCB_4;
        alu_control_s = ALU_ADD;
        result_src_s  = RES_ALUOUT;
        if (ready_s) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end

      S_DECODE: begin
        if (!cond_ok_s) begin
          state_d = S_FETCH;
        end else begin
          case (op)
            OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            default: begin
              undef_s = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
      end

      S_EXECR, S_EXECI: begin
        alu_src_b_s   = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RM;
        imm_src_s     = IMM_8;
        alu_control_s = cmd_alu(cmd_s);
        if (funct[0] || is_cmp_s) begin
          flags_d = alu_flags;
        end else begin
          flags_d = flags_q;
        end
        if (!cmd_ok_s) begin
          undef_s = 1'b1;
          state_d = S_FETCH;
        end else if (is_cmp_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end

      S_ALUWB: begin
        result_src_s = RES_ALUREG;
        // A write to R15 is a jump: it goes to PC, not the register file
        if (rd_pc_s) begin
          pc_write_s = 1'b1;
        end else begin
          reg_write_s = 1'b1;
        end
        state_d = S_FETCH;
      end

      S_MEMADR: begin
        alu_control_s = ALU_ADD;
        alu_src_b_s   = SRCB_IMM;
        imm_src_s     = IMM_12;
        state_d       = funct[0] ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        state_d   = ready_s ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        result_src_s = RES_RDATA;
        if (rd_pc_s) begin
          pc_write_s = 1'b1;
        end else begin
          reg_write_s = 1'b1;
        end
        state_d = S_FETCH;
      end

      S_MEMWR: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src_s   = 1'b1;
        state_d     = ready_s ? S_FETCH : S_MEMWR;
      end

      S_BRANCH: begin
        alu_src_a_s   = SRCA_PC;
        alu_src_b_s   = SRCB_IMM;
        imm_src_s     = IMM_24;
        alu_control_s = ALU_ADD;
        result_src_s  = RES_ALUOUT;
        pc_write_s    = 1'b1;
        // BL: the datapath routes PC+4 into R14
        if (funct[4]) begin
          reg_write_s = 1'b1;
          link_s      = 1'b1;
        end else begin
          reg_write_s = 1'b0;
          link_s      = 1'b0;
        end
        state_d = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Memory request and FETCH-time writes are suppressed while in reset
  assign mem.mem_req   = mem_req_s & reset_n;
  assign mem.mem_write = mem_write_s;
  assign mem.adr_src   = adr_src_s;
  assign ir_write      = ir_write_s & reset_n;
  assign pc_write      = pc_write_s & reset_n;
  assign reg_write     = reg_write_s;
  assign link          = link_s;
  assign undef         = undef_s;
  assign alu_src_a     = alu_src_a_s;
  assign alu_src_b     = alu_src_b_s;
  assign alu_control   = alu_control_s;
  assign imm_src       = imm_src_s;
  assign result_src    = result_src_s;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model that
// expands each instruction into its expected per-cycle control trace.
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       link;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] imm;
    logic [1:0] res;
    logic       undef;
    logic [3:0] flags;
  } outv_t;

  logic       clk;
  logic       reset_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       rdy_tb;

  multicycle_control_if if_a ();
  multicycle_control_if if_b ();
  assign if_a.mem_ready = rdy_tb;
  assign if_b.mem_ready = rdy_tb;

  logic       irw_a, pcw_a, rw_a, lk_a, un_a;
  logic [1:0] sa_a, sb_a, is_a, rs_a;
  logic [2:0] ac_a;
  logic [3:0] fl_a;
  logic       irw_b, pcw_b, rw_b, lk_b, un_b;
  logic [1:0] sa_b, sb_b, is_b, rs_b;
  logic [2:0] ac_b;
  logic [3:0] fl_b;

  multicycle_control #(.COND_FULL(1'b1), .MEM_HS(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .cond(cond), .op(op), .funct(funct),
    .rd(rd), .alu_flags(alu_flags), .mem(if_a), .ir_write(irw_a),
    .pc_write(pcw_a), .reg_write(rw_a), .link(lk_a), .alu_src_a(sa_a),
    .alu_src_b(sb_a), .alu_control(ac_a), .imm_src(is_a),
    .result_src(rs_a), .flags_q(fl_a), .undef(un_a)
  );

  multicycle_control #(.COND_FULL(1'b0), .MEM_HS(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .cond(cond), .op(op), .funct(funct),
    .rd(rd), .alu_flags(alu_flags), .mem(if_b), .ir_write(irw_b),
    .pc_write(pcw_b), .reg_write(rw_b), .link(lk_b), .alu_src_a(sa_b),
    .alu_src_b(sb_b), .alu_control(ac_b), .imm_src(is_b),
    .result_src(rs_b), .flags_q(fl_b), .undef(un_b)
  );

  outv_t act_a, act_b, exp_cur;
  assign act_a = {if_a.mem_req, if_a.mem_write, if_a.adr_src, irw_a, pcw_a, rw_a,
                  lk_a, sa_a, sb_a, ac_a, is_a, rs_a, un_a, fl_a};
  assign act_b = {if_b.mem_req, if_b.mem_write, if_b.adr_src, irw_b, pcw_b, rw_b,
                  lk_b, sa_b, sb_b, ac_b, is_b, rs_b, un_b, fl_b};

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  bit   sel = 1'b0;
  int   cyc = 0;

  // model state
  logic [3:0] mflags;
  bit         cur_full;
  bit         cur_hs;
  outv_t      eq[$];
  bit         rq[$];
  logic [3:0] fq[$];
  logic [3:0] cmd_tab [0:5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle comparison of the selected DUT against the model trace
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      outv_t act;
      act = sel ? act_b : act_a;
      n_cmp++;
      if (act !== exp_cur) begin
        n_bad++;
        $display("FAIL trace cyc=%0d dut=%0d got=%b want=%b (req,wr,adr,irw,pcw,rw,lnk,a,b,alu,imm,res,und,nzcv)",
                 cyc, sel, act, exp_cur);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f, input bit full);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    if (!full) return (c == 4'b0000) ? z : (c == 4'b0001) ? !z : (c == 4'b1110);
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic outv_t zv();
    outv_t v;
    v = '0;
    return v;
  endfunction

  // rmode: 0 memory not ready, 1 memory ready, 2 don't care
  task automatic put(input outv_t v, input int rmode, input logic [3:0] af);
    bit r;
    v.flags = mflags;
    if (!cur_hs || rmode == 2) r = 1'($urandom_range(0, 1));
    else r = (rmode == 1);
    eq.push_back(v);
    rq.push_back(r);
    fq.push_back(af);
  endtask

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  // Expand one instruction into its expected cycle-by-cycle control trace
  task automatic build(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                       input logic [3:0] r, input logic [3:0] af, input int wf_in, input int wm_in);
    outv_t v;
    int wf, wm;
    logic [3:0] cmd;
    bit valid;
    logic [2:0] alu;
    wf = cur_hs ? wf_in : 0;
    wm = cur_hs ? wm_in : 0;
    eq.delete(); rq.delete(); fq.delete();
    v = zv(); v.mem_req = 1'b1; v.src_a = 2'b01; v.src_b = 2'b10; v.res = 2'b10;
    for (int i = 0; i < wf; i++) put(v, 0, rnd4());
    v.ir_write = 1'b1; v.pc_write = 1'b1;
    put(v, 1, rnd4());
    v = zv();
    if (!cond_pass(c, mflags, cur_full)) begin
      put(v, 2, rnd4());
      return;
    end
    if (o == 2'b11) begin
      v.undef = 1'b1;
      put(v, 2, rnd4());
      return;
    end
    put(v, 2, rnd4());
    if (o == 2'b00) begin
      cmd = fn[4:1];
      valid = 1'b1;
      case (cmd)
        4'b0100: alu = 3'd0;
        4'b0010: alu = 3'd1;
        4'b1010: alu = 3'd1;
        4'b0000: alu = 3'd2;
        4'b1100: alu = 3'd3;
        4'b1101: alu = 3'd4;
        default: begin alu = 3'd0; valid = 1'b0; end
      endcase
      v = zv(); v.src_b = fn[5] ? 2'b01 : 2'b00; v.alu = alu; v.undef = !valid;
      put(v, 2, af);
      if (fn[0] || cmd == 4'b1010) mflags = af;
      if (valid && cmd != 4'b1010) begin
        v = zv();
        if (r == 4'd15) v.pc_write = 1'b1; else v.reg_write = 1'b1;
        put(v, 2, rnd4());
      end
    end else if (o == 2'b01) begin
      v = zv(); v.src_b = 2'b01; v.imm = 2'b01;
      put(v, 2, rnd4());
      v = zv(); v.mem_req = 1'b1; v.adr_src = 1'b1; v.mem_write = !fn[0];
      for (int i = 0; i < wm; i++) put(v, 0, rnd4());
      put(v, 1, rnd4());
      if (fn[0]) begin
        v = zv(); v.res = 2'b01;
        if (r == 4'd15) v.pc_write = 1'b1; else v.reg_write = 1'b1;
        put(v, 2, rnd4());
      end
    end else begin
      v = zv(); v.src_a = 2'b01; v.src_b = 2'b01; v.imm = 2'b10; v.res = 2'b10;
      v.pc_write = 1'b1; v.reg_write = fn[4]; v.link = fn[4];
      put(v, 2, rnd4());
    end
  endtask

  task automatic step(input outv_t e, input bit r, input logic [3:0] f);
    rdy_tb = r;
    alu_flags = f;
    exp_cur = e;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive up to n cycles of the current trace (whole trace when n is large)
  task automatic run_n(input int n);
    int k;
    k = (n < eq.size()) ? n : eq.size();
    for (int i = 0; i < k; i++) step(eq[i], rq[i], fq[i]);
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                       input logic [3:0] r, input logic [3:0] af, input int wf, input int wm);
    cond = c; op = o; funct = fn; rd = r;
    build(c, o, fn, r, af, wf, wm);
  endtask

  function automatic outv_t rst_v();
    outv_t v;
    v = zv(); v.src_a = 2'b01; v.src_b = 2'b10; v.res = 2'b10;
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    mflags = 4'b0000;
    exp_cur = rst_v();
    chk_en = 1'b1;
    rdy_tb = 1'($urandom_range(0, 1));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic rand_instr();
    logic [5:0] fn;
    logic [3:0] c;
    logic [3:0] r;
    c  = ($urandom_range(0, 1) == 0) ? 4'hE : rnd4();
    fn = 6'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) fn[4:1] = cmd_tab[$urandom_range(0, 5)];
    r  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
    instr(c, 2'($urandom_range(0, 3)), fn, r, rnd4(),
          $urandom_range(0, 3), $urandom_range(0, 3));
    run_n(1000);
  endtask

  initial begin
    cmd_tab[0] = 4'b0100; cmd_tab[1] = 4'b0010; cmd_tab[2] = 4'b0000;
    cmd_tab[3] = 4'b1100; cmd_tab[4] = 4'b1101; cmd_tab[5] = 4'b1010;
    cond = 4'hE; op = 2'b00; funct = 6'b0; rd = 4'd0; alu_flags = 4'b0; rdy_tb = 1'b0;
    exp_cur = rst_v();
    sel = 1'b0; cur_full = 1'b1; cur_hs = 1'b1;
    do_reset();

    // ADD R1, #5 with no wait states
    instr(4'hE, 2'b00, 6'b101000, 4'd1, 4'b1111, 0, 0);
    chk("len_add", eq.size(), 4);
    chk("add_rw_c4", eq[3].reg_write, 1);
    run_n(1000);
    chk("add_flags", fl_a, 4'b0000);

    // CMP sets Z, then BEQ taken and BNE not taken
    instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 0, 0);
    chk("len_cmp", eq.size(), 3);
    run_n(1000);
    chk("cmp_flags", fl_a, 4'b0100);
    instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0);
    chk("len_beq", eq.size(), 3);
    run_n(1000);
    instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0);
    chk("len_bne", eq.size(), 2);
    run_n(1000);

    // LDR with three wait states in MEMRD
    instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, 0, 3);
    chk("len_ldr_w3", eq.size(), 8);
    chk("ldr_wb_res", eq[7].res, 2'b01);
    run_n(1000);

    // STR with no waits, BL, undefined op
    instr(4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000, 0, 0);
    chk("len_str", eq.size(), 4);
    run_n(1000);
    instr(4'hE, 2'b10, 6'b010000, 4'd0, 4'b0000, 0, 0);
    chk("bl_branch", {eq[2].reg_write, eq[2].link, eq[2].pc_write, eq[2].imm}, 5'b11110);
    run_n(1000);
    instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 0, 0);
    chk("undef_pulse", {eq.size(), eq[1].undef}, {32'd2, 1'b1} >> 0);
    run_n(1000);

    // Randomized instruction stream on the full-featured instance
    for (int i = 0; i < 300; i++) rand_instr();

    // Reset in the middle of a waiting store, after flags were set
    instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b1001, 0, 0);
    run_n(1000);
    instr(4'hE, 2'b01, 6'b000000, 4'd3, 4'b0000, 0, 6);
    run_n(5);
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mem_write", if_a.mem_write, 0);
    chk("rst_mem_req", if_a.mem_req, 0);
    chk("rst_flags", fl_a, 4'b0000);
    mflags = 4'b0000;
    exp_cur = rst_v();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // GE with flags 0000 executes when all codes are evaluated
    instr(4'hA, 2'b00, 6'b101000, 4'd3, 4'b0000, 0, 0);
    chk("len_ge_full", eq.size(), 4);
    run_n(1000);

    // Reduced-condition, no-handshake instance
    do_reset();
    sel = 1'b1; cur_full = 1'b0; cur_hs = 1'b0;
    instr(4'hA, 2'b00, 6'b101000, 4'd3, 4'b0000, 0, 0);
    chk("len_ge_lite", eq.size(), 2);
    run_n(1000);
    for (int i = 0; i < 120; i++) rand_instr();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop so the run always terminates
  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
